// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM states,
// condition codes, FunSel codes and flag bit positions.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned COND_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic [COND_W-1:0] COND_AL = 3'd0;
  localparam logic [COND_W-1:0] COND_EQ = 3'd1;
  localparam logic [COND_W-1:0] COND_NE = 3'd2;
  localparam logic [COND_W-1:0] COND_CS = 3'd3;
  localparam logic [COND_W-1:0] COND_CC = 3'd4;
  localparam logic [COND_W-1:0] COND_MI = 3'd5;
  localparam logic [COND_W-1:0] COND_PL = 3'd6;
  localparam logic [COND_W-1:0] COND_VS = 3'd7;

  localparam logic [OP_W-1:0] FS_ADD = 4'b0100;
  localparam logic [OP_W-1:0] FS_SUB = 4'b0101;
  localparam logic [OP_W-1:0] FS_CMP = 4'b0110;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_O = 0;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle between a command source (master)
// and the ALU sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int unsigned REG_AW = 2
);
  import alu_seq_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_load;
  logic [DATA_W-1:0]    cmd_imm;
  logic [OP_W-1:0]      cmd_op;
  logic [REG_AW-1:0]    cmd_srca;
  logic [REG_AW-1:0]    cmd_srcb;
  logic [REG_AW-1:0]    cmd_dst;
  logic [COND_W-1:0]    cmd_cond;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_data;
  logic [FLAG_W-1:0]    rsp_flags;
  logic                 rsp_skipped;

  modport master (
    output cmd_valid, cmd_load, cmd_imm, cmd_op, cmd_srca, cmd_srcb, cmd_dst,
           cmd_cond, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_skipped
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_imm, cmd_op, cmd_srca, cmd_srcb, cmd_dst,
           cmd_cond, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_skipped
  );

endinterface

// File: rtl/alu_cond_eval.sv
// Condition-code evaluator: decides whether a command executes given the
// shadow flags {Z,C,N,O}.
module alu_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [FLAG_W-1:0] flags,
  input  logic [COND_W-1:0] cond,
  output logic              pass_c
);

  always_comb begin
    pass_c = 1'b1;
    case (cond)
      COND_AL: pass_c = 1'b1;
      COND_EQ: pass_c = flags[FLAG_Z];
      COND_NE: pass_c = !flags[FLAG_Z];
      COND_CS: pass_c = flags[FLAG_C];
      COND_CC: pass_c = !flags[FLAG_C];
      COND_MI: pass_c = flags[FLAG_N];
      COND_PL: pass_c = !flags[FLAG_N];
      COND_VS: pass_c = flags[FLAG_O];
      default: pass_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issuing master for the 8-bit ALU: register file, one command in flight,
// shadow flags. Define ALU_SEQ_COND_EN to enable conditional execution.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned     REG_AW      = 2,
  parameter logic [OP_W-1:0] IDLE_FUNSEL = 4'b0000
) (
  input  logic               CLK,
  input  logic               RST,
  alu_op_sequencer_if.slave  bus,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_funsel,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic [FLAG_W-1:0]  alu_zcno,
  output logic [FLAG_W-1:0]  flags
);

  localparam int unsigned NREG = 32'(1) << REG_AW;

  state_e              state, state_nxt;
  logic [DATA_W-1:0]   regs [NREG];
  logic                cmd_ready_q, rsp_valid_q, rsp_skip_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [FLAG_W-1:0]   rsp_flags_q;
  logic [OP_W-1:0]     op_q;
  logic [REG_AW-1:0]   dst_q;
  logic                accept_c, cond_pass_c;

`ifdef ALU_SEQ_COND_EN
  alu_cond_eval u_cond (
    .flags  (flags),
    .cond   (bus.cmd_cond),
    .pass_c (cond_pass_c)
  );
`else
  // Every command executes; the skip path is unreachable and folds to 0.
  logic unused_cond_c;
  assign unused_cond_c = ^bus.cmd_cond;
  assign cond_pass_c   = 1'b1;
`endif

  assign accept_c = (state == ST_IDLE) && bus.cmd_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready_q <= (state_nxt == ST_IDLE);
      rsp_valid_q <= (state_nxt == ST_RESP);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (bus.cmd_load || !cond_pass_c) state_nxt = ST_RESP;
          else                              state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand issue, result capture, register write-back.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_funsel  <= IDLE_FUNSEL;
      flags       <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_skip_q  <= 1'b0;
      op_q        <= '0;
      dst_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            rsp_flags_q <= flags;
            if (bus.cmd_load) begin
              regs[bus.cmd_dst] <= bus.cmd_imm;
              rsp_data_q        <= bus.cmd_imm;
              rsp_skip_q        <= 1'b0;
            end else if (!cond_pass_c) begin
              rsp_data_q <= '0;
              rsp_skip_q <= 1'b1;
            end else begin
              alu_a      <= regs[bus.cmd_srca];
              alu_b      <= regs[bus.cmd_srcb];
              alu_funsel <= bus.cmd_op;
              op_q       <= bus.cmd_op;
              dst_q      <= bus.cmd_dst;
              rsp_skip_q <= 1'b0;
            end
          end
        end
        ST_ISSUE: alu_funsel <= IDLE_FUNSEL;
        ST_CAPTURE: begin
          rsp_data_q  <= alu_out;
          rsp_flags_q <= alu_zcno;
          flags       <= alu_zcno;
          if (op_q != FS_CMP) regs[dst_q] <= alu_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_flags   = rsp_flags_q;
  assign bus.rsp_skipped = rsp_skip_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural registered ALU
// standing in for the real alu.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_COND_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif
  localparam logic [3:0] IDLE_FS = 4'b0000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_funsel, alu_zcno, flags;
  int         checks = 0;
  int         errors = 0;

  alu_op_sequencer_if #(.REG_AW(2)) bus ();

  alu_op_sequencer #(.REG_AW(2), .IDLE_FUNSEL(IDLE_FS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_funsel (alu_funsel),
    .alu_out    (alu_out),
    .alu_zcno   (alu_zcno),
    .flags      (flags)
  );

  always #5 CLK = ~CLK;

  // ALU stand-in: {Z,C,N,O,result}; subtract is a + ~b + 1 with C = carry out.
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] fs);
    logic [8:0] s;
    logic       o;
    case (fs)
      4'b0100: begin
        s = {1'b0, a} + {1'b0, b};
        o = (a[7] == b[7]) && (s[7] != a[7]);
      end
      4'b0101, 4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        o = (a[7] != b[7]) && (s[7] != a[7]);
      end
      default: begin
        s = {1'b0, a};
        o = 1'b0;
      end
    endcase
    return {s[7:0] == 8'd0, s[8], s[7], o, s[7:0]};
  endfunction

  always @(posedge CLK) {alu_zcno, alu_out} <= alu_f(alu_a, alu_b, alu_funsel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_cmd(input string tag, input logic ld, input logic [7:0] imm,
                         input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] d, input logic [2:0] cond, input int exp_lat,
                         input logic [7:0] exp_data, input logic [3:0] exp_flags,
                         input logic exp_skip, input int hold);
    int lat;
    @(negedge CLK);
    chk({tag, ".cmd_ready_pre"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_imm   = imm;
    bus.cmd_op    = op;
    bus.cmd_srca  = sa;
    bus.cmd_srcb  = sb;
    bus.cmd_dst   = d;
    bus.cmd_cond  = cond;
    bus.rsp_ready = (hold == 0);
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      if (lat == 1) chk({tag, ".funsel_issue"}, 32'(alu_funsel), 32'(op));
      if (lat == 2) chk({tag, ".funsel_idle"}, 32'(alu_funsel), 32'(IDLE_FS));
      @(posedge CLK);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
    chk({tag, ".rsp_flags"}, 32'(bus.rsp_flags), 32'(exp_flags));
    chk({tag, ".rsp_skipped"}, 32'(bus.rsp_skipped), 32'(exp_skip));
    chk({tag, ".flags"}, 32'(flags), 32'(exp_flags));
    chk({tag, ".cmd_ready_busy"}, 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      #1;
      chk({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".hold_data"}, 32'(bus.rsp_data), 32'(exp_data));
      chk({tag, ".hold_ready"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk({tag, ".post_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_imm   = '0;
    bus.cmd_op    = '0;
    bus.cmd_srca  = '0;
    bus.cmd_srcb  = '0;
    bus.cmd_dst   = '0;
    bus.cmd_cond  = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst.rsp_flags", 32'(bus.rsp_flags), 32'd0);
    chk("rst.rsp_skipped", 32'(bus.rsp_skipped), 32'd0);
    chk("rst.flags", 32'(flags), 32'd0);
    chk("rst.alu_a", 32'(alu_a), 32'd0);
    chk("rst.alu_b", 32'(alu_b), 32'd0);
    chk("rst.alu_funsel", 32'(alu_funsel), 32'(IDLE_FS));
    @(negedge CLK);
    RST = 1'b0;

    run_cmd("ld_r0", 1'b1, 8'h7F, 4'h0, 2'd0, 2'd0, 2'd0, COND_AL, 1, 8'h7F, 4'b0000, 1'b0, 0);
    run_cmd("ld_r1", 1'b1, 8'h01, 4'h0, 2'd0, 2'd0, 2'd1, COND_AL, 1, 8'h01, 4'b0000, 1'b0, 0);
    run_cmd("add_r2", 1'b0, 8'h00, FS_ADD, 2'd0, 2'd1, 2'd2, COND_AL, 3, 8'h80, 4'b0011, 1'b0, 0);
    run_cmd("sub_r3", 1'b0, 8'h00, FS_SUB, 2'd1, 2'd1, 2'd3, COND_AL, 3, 8'h00, 4'b1100, 1'b0, 0);
    run_cmd("add_ne", 1'b0, 8'h00, FS_ADD, 2'd0, 2'd1, 2'd3, COND_NE,
            COND_EN ? 1 : 3, COND_EN ? 8'h00 : 8'h80,
            COND_EN ? 4'b1100 : 4'b0011, COND_EN, 0);
    // R3 is 00 if the NE add was skipped, 80 if it ran; R3+R3 yields 00 either way.
    run_cmd("add_r3r3", 1'b0, 8'h00, FS_ADD, 2'd3, 2'd3, 2'd3, COND_AL, 3, 8'h00,
            COND_EN ? 4'b1000 : 4'b1101, 1'b0, 0);
    run_cmd("cmp_r0r1", 1'b0, 8'h00, FS_CMP, 2'd0, 2'd1, 2'd2, COND_AL, 3, 8'h7E, 4'b0100, 1'b0, 0);
    // R2 must still hold 80 after the compare.
    run_cmd("add_cs", 1'b0, 8'h00, FS_ADD, 2'd2, 2'd3, 2'd3, COND_CS, 3, 8'h80, 4'b0010, 1'b0, 0);
    run_cmd("ld_hold", 1'b1, 8'h55, 4'h0, 2'd0, 2'd0, 2'd3, COND_AL, 1, 8'h55, 4'b0010, 1'b0, 5);

    // Reset lands during CAPTURE of an add into R2.
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = FS_ADD;
    bus.cmd_srca  = 2'd3;
    bus.cmd_srcb  = 2'd1;
    bus.cmd_dst   = 2'd2;
    bus.cmd_cond  = COND_AL;
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("rstmid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstmid.alu_funsel", 32'(alu_funsel), 32'(IDLE_FS));
    chk("rstmid.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rstmid.flags", 32'(flags), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    run_cmd("add_r2r2", 1'b0, 8'h00, FS_ADD, 2'd2, 2'd2, 2'd1, COND_AL, 3, 8'h00, 4'b1000, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
